// File: rtl/enemy_spawn_ctrl.sv
// Spawn scheduler for enemy1: LFSR-randomised x, level-dependent interval and speed,
// one offer at a time toward the slot allocator over a valid/ready handshake.
module enemy_spawn_ctrl #(
  parameter int          H_DISP        = 640,
  parameter int          X_SIZE        = 57,
  parameter int          BASE_INTERVAL = 200,
  parameter int          MIN_INTERVAL  = 40,
  parameter int          LEVEL_STEP    = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic        clk_run,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        clear_i,
  input  logic        spawn_ready_i,
  output logic        spawn_valid_o,
  output logic [9:0]  spawn_x_o,
  output logic [1:0]  spawn_speed_o,
  output logic [1:0]  level_o,
  output logic [15:0] spawn_total_o
);

  localparam int          X_RANGE  = H_DISP - X_SIZE + 1;
  localparam int          CNT_MAX  = (BASE_INTERVAL > MIN_INTERVAL) ? BASE_INTERVAL : MIN_INTERVAL;
  localparam int          CW       = $clog2(CNT_MAX + 1);
  localparam int          LW       = $clog2(LEVEL_STEP + 1);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [9:0]  X_RANGE_W = 10'(X_RANGE);

  typedef enum logic {COUNT, OFFER} state_t;

  state_t          state, state_next;
  logic [15:0]     lfsr;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   interval;
  logic [CW-1:0]   interval_tab [4];
  logic [LW-1:0]   level_cnt;
  logic [9:0]      cand, x_map;
  logic [1:0]      speed_sel;
  logic            latch, xfer;

  // Interval per level, clamped at the floor, resolved at elaboration.
  for (genvar gi = 0; gi < 4; gi++) begin : g_interval
    localparam int SHIFTED = BASE_INTERVAL >> gi;
    localparam int IVAL    = (SHIFTED < MIN_INTERVAL) ? MIN_INTERVAL : SHIFTED;
    assign interval_tab[gi] = CW'(IVAL);
  end

  assign interval = interval_tab[level_o];

  assign cand  = lfsr[9:0];
  assign x_map = (cand >= X_RANGE_W) ? (cand - X_RANGE_W) : cand;

  always_comb begin
    speed_sel = 2'b01;
    case (level_o)
      2'd0:    speed_sel = 2'b01;
      2'd1:    speed_sel = lfsr[15] ? 2'b11 : 2'b01;
      2'd2:    speed_sel = lfsr[15] ? 2'b10 : 2'b11;
      default: speed_sel = 2'b10;
    endcase
  end

  always_comb begin
    state_next = state;
    latch      = 1'b0;
    xfer       = 1'b0;
    case (state)
      COUNT: begin
        if (en_i && (cnt == (interval - CW'(1)))) begin
          latch      = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (spawn_ready_i) begin
          xfer       = 1'b1;
          state_next = COUNT;
        end
      end
      default: state_next = COUNT;
    endcase
  end

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      state <= COUNT;
    end else if (clear_i) begin
      state <= COUNT;
    end else begin
      state <= state_next;
    end
  end

  // Free-running: a restart does not replay the same enemy pattern.
  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      level_cnt     <= '0;
      spawn_x_o     <= '0;
      spawn_speed_o <= 2'b00;
      level_o       <= 2'd0;
      spawn_total_o <= '0;
    end else if (clear_i) begin
      cnt           <= '0;
      level_cnt     <= '0;
      spawn_x_o     <= '0;
      spawn_speed_o <= 2'b00;
      level_o       <= 2'd0;
      spawn_total_o <= '0;
    end else begin
      if ((state == COUNT) && en_i) begin
        cnt <= latch ? '0 : (cnt + CW'(1));
      end
      if (latch) begin
        spawn_x_o     <= x_map;
        spawn_speed_o <= speed_sel;
      end
      if (xfer) begin
        if (spawn_total_o != 16'hFFFF) begin
          spawn_total_o <= spawn_total_o + 16'd1;
        end
        // Level change takes effect on the interval of the next COUNT period.
        if (level_cnt == LW'(LEVEL_STEP - 1)) begin
          level_cnt <= '0;
          if (level_o != 2'd3) begin
            level_o <= level_o + 2'd1;
          end
        end else begin
          level_cnt <= level_cnt + LW'(1);
        end
      end
    end
  end

  assign spawn_valid_o = (state == OFFER);

endmodule

// File: tb/tb_enemy_spawn_ctrl.sv
// Bench for enemy_spawn_ctrl: directed scenarios plus random traffic, all outputs
// compared every cycle against a spawn-count based model.
module tb_enemy_spawn_ctrl;

  logic        clk_run = 1'b0;
  logic        rst_n = 1'b1;
  logic        en_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        spawn_ready_i = 1'b0;
  logic        spawn_valid_o;
  logic [9:0]  spawn_x_o;
  logic [1:0]  spawn_speed_o;
  logic [1:0]  level_o;
  logic [15:0] spawn_total_o;

  enemy_spawn_ctrl dut (
    .clk_run       (clk_run),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .spawn_ready_i (spawn_ready_i),
    .spawn_valid_o (spawn_valid_o),
    .spawn_x_o     (spawn_x_o),
    .spawn_speed_o (spawn_speed_o),
    .level_o       (level_o),
    .spawn_total_o (spawn_total_o)
  );

  always #5 clk_run = ~clk_run;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit run_chk  = 1'b0;

  task automatic check(input string nm, input int actual, input int expected);
    chk_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", nm, actual, expected);
  endtask

  // Reference model: level and total follow from the accepted-spawn count.
  logic [15:0] m_lfsr  = 16'hACE1;
  bit          m_offer = 1'b0;
  int          m_x     = 0;
  int          m_speed = 0;
  int          m_acc   = 0;
  int          m_ticks = 0;

  function automatic int level_of(input int acc);
    return (acc / 8 > 3) ? 3 : acc / 8;
  endfunction

  function automatic int interval_of(input int lvl);
    int v;
    v = 200 >> lvl;
    return (v < 40) ? 40 : v;
  endfunction

  function automatic int map_x(input int c);
    return (c >= 584) ? c - 584 : c;
  endfunction

  function automatic int speed_of(input int lvl, input bit msb);
    case (lvl)
      0:       return 1;
      1:       return msb ? 3 : 1;
      2:       return msb ? 2 : 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk_run or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 16'hACE1; m_offer <= 1'b0; m_x <= 0; m_speed <= 0; m_acc <= 0; m_ticks <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      if (clear_i) begin
        m_offer <= 1'b0; m_x <= 0; m_speed <= 0; m_acc <= 0; m_ticks <= 0;
      end else if (m_offer) begin
        if (spawn_ready_i) begin
          m_offer <= 1'b0;
          m_acc   <= m_acc + 1;
        end
      end else if (en_i) begin
        if (m_ticks == interval_of(level_of(m_acc)) - 1) begin
          m_offer <= 1'b1;
          m_x     <= map_x(int'(m_lfsr[9:0]));
          m_speed <= speed_of(level_of(m_acc), m_lfsr[15]);
          m_ticks <= 0;
        end else begin
          m_ticks <= m_ticks + 1;
        end
      end
    end
  end

  always @(negedge clk_run) begin
    if (run_chk) begin
      check("cyc_valid", int'(spawn_valid_o), int'(m_offer));
      check("cyc_x",     int'(spawn_x_o),     m_x);
      check("cyc_speed", int'(spawn_speed_o), m_speed);
      check("cyc_level", int'(level_o),       level_of(m_acc));
      check("cyc_total", int'(spawn_total_o), (m_acc > 65535) ? 65535 : m_acc);
    end
  end

  task automatic step();
    @(posedge clk_run);
    #1;
  endtask

  task automatic wait_valid(input string nm, input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!spawn_valid_o && n < budget);
    check({nm, "_seen"}, int'(spawn_valid_o), 1);
  endtask

  task automatic run_until_acc(input int target);
    int guard;
    guard = 0;
    while (m_acc < target && guard < 6000) begin
      step();
      guard++;
    end
    check($sformatf("reach_acc_%0d", target), m_acc, target);
  endtask

  // Hold the counter one tick short of expiry until the LFSR shows the wanted low bits.
  task automatic hit_x(input int target, input int exp_x);
    int guard;
    spawn_ready_i = 1'b0;
    en_i = 1'b1;
    guard = 0;
    while (!(!m_offer && m_ticks == interval_of(level_of(m_acc)) - 1) && guard < 1000) begin
      step();
      guard++;
    end
    en_i = 1'b0;
    guard = 0;
    while (int'(m_lfsr[9:0]) != target && guard < 40000) begin
      step();
      guard++;
    end
    check($sformatf("lfsr_hit_%0d", target), int'(m_lfsr[9:0]), target);
    en_i = 1'b1;
    step();
    check($sformatf("x_valid_%0d", target), int'(spawn_valid_o), 1);
    check($sformatf("x_for_%0d", target), int'(spawn_x_o), exp_x);
    spawn_ready_i = 1'b1;
    step();
    spawn_ready_i = 1'b0;
    check($sformatf("x_xfer_%0d", target), int'(spawn_valid_o), 0);
  endtask

  int n, n2, cap_x, cap_speed, cap_total;
  int pin_in  [5] = '{583, 584, 1023, 0, 600};
  int pin_out [5] = '{583, 0, 439, 0, 16};
  int pin_iv  [4] = '{200, 100, 50, 40};

  initial begin
    for (int i = 0; i < 5; i++) check("model_map_x", map_x(pin_in[i]), pin_out[i]);
    for (int i = 0; i < 4; i++) check("model_interval", interval_of(i), pin_iv[i]);

    #1 rst_n = 1'b0;
    run_chk = 1'b1;
    en_i = 1'b1;
    spawn_ready_i = 1'b1;
    @(posedge clk_run);
    @(posedge clk_run);
    #1 rst_n = 1'b1;
    check("rst_valid", int'(spawn_valid_o), 0);
    check("rst_x",     int'(spawn_x_o), 0);
    check("rst_total", int'(spawn_total_o), 0);

    // Free-flowing spawns: offers at edges 200 and 401.
    wait_valid("first", 300, n);
    check("first_offer_cycle", n, 200);
    check("first_speed", int'(spawn_speed_o), 1);
    step();
    check("first_one_cycle", int'(spawn_valid_o), 0);
    check("first_total", int'(spawn_total_o), 1);
    wait_valid("second", 300, n2);
    check("second_offer_cycle", n + 1 + n2, 401);

    // Back-pressure for 500 cycles.
    spawn_ready_i = 1'b0;
    cap_x = int'(spawn_x_o);
    cap_speed = int'(spawn_speed_o);
    cap_total = int'(spawn_total_o);
    repeat (500) step();
    check("bp_valid", int'(spawn_valid_o), 1);
    check("bp_x", int'(spawn_x_o), cap_x);
    check("bp_speed", int'(spawn_speed_o), cap_speed);
    check("bp_total", int'(spawn_total_o), cap_total);
    spawn_ready_i = 1'b1;
    step();
    check("bp_drop", int'(spawn_valid_o), 0);
    check("bp_total_inc", int'(spawn_total_o), cap_total + 1);
    wait_valid("bp_next", 300, n);
    check("bp_next_gap", n, 200);

    // Pause counting for 50 cycles mid-interval.
    step();
    repeat (20) step();
    en_i = 1'b0;
    repeat (50) step();
    en_i = 1'b1;
    wait_valid("pause", 400, n);
    check("pause_delay", 20 + 50 + n, 250);
    en_i = 1'b0;
    spawn_ready_i = 1'b0;
    repeat (10) step();
    check("en_low_offer_held", int'(spawn_valid_o), 1);
    en_i = 1'b1;
    spawn_ready_i = 1'b1;
    step();
    check("en_low_then_xfer", int'(spawn_valid_o), 0);

    // x mapping boundaries.
    hit_x(583, 583);
    hit_x(584, 0);
    hit_x(1023, 439);

    // Difficulty progression.
    spawn_ready_i = 1'b1;
    en_i = 1'b1;
    run_until_acc(8);
    check("level1", int'(level_o), 1);
    wait_valid("lvl1", 300, n);
    check("lvl1_gap", n, 100);
    run_until_acc(32);
    check("level3", int'(level_o), 3);
    wait_valid("lvl3", 300, n);
    check("lvl3_gap", n, 40);
    check("lvl3_speed", int'(spawn_speed_o), 2);
    wait_valid("lvl3b", 300, n);
    check("lvl3_period", n, 41);
    run_until_acc(48);
    check("level_sat", int'(level_o), 3);

    // Clear together with a handshake.
    spawn_ready_i = 1'b0;
    wait_valid("pre_clear", 100, n);
    spawn_ready_i = 1'b1;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    spawn_ready_i = 1'b0;
    check("clr_valid", int'(spawn_valid_o), 0);
    check("clr_total", int'(spawn_total_o), 0);
    check("clr_level", int'(level_o), 0);
    wait_valid("post_clear", 300, n);
    check("post_clear_gap", n, 200);
    spawn_ready_i = 1'b1;

    // Asynchronous reset between clock edges.
    repeat (30) step();
    @(posedge clk_run);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(spawn_valid_o), 0);
    check("arst_x", int'(spawn_x_o), 0);
    check("arst_speed", int'(spawn_speed_o), 0);
    check("arst_level", int'(level_o), 0);
    check("arst_total", int'(spawn_total_o), 0);
    step();
    rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 8000; i++) begin
      en_i          = ($urandom % 8) != 0;
      spawn_ready_i = ($urandom % 3) != 0;
      clear_i       = ($urandom % 700) == 0;
      step();
    end
    clear_i = 1'b0;
    step();

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/enemy_spawn_ctrl.md
Name: enemy_spawn_ctrl

Overview:
- Upstream stage of the enemy1 object block; decides when a new enemy1 appears, its x position and its speed code.
- Replaces the fixed trigger counter and the hard-coded x position (300) with an LFSR-randomised x, a difficulty level that shortens the spawn interval, and a valid/ready handshake toward the enemy slot allocator.
- Runs in the game-logic domain (clk_run), one spawn offer at a time.

Parameters:
- H_DISP, 640, horizontal display width in pixels.
- X_SIZE, 57, enemy1 sprite width; legal x is 0..H_DISP-X_SIZE.
- BASE_INTERVAL, 200, clk_run cycles between spawns at level 0.
- MIN_INTERVAL, 40, floor on the spawn interval.
- LEVEL_STEP, 8, accepted spawns per difficulty level increment.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- clk_run  in  1  game-logic clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en_i  in  1  game running; low pauses interval counting.
- clear_i  in  1  synchronous game restart; same effect as reset except the LFSR keeps running.
- spawn_ready_i  in  1  enemy block has a free slot and accepts the offer.
- spawn_valid_o  out  1  offer present.
- spawn_x_o  out  10  x position of the new enemy.
- spawn_speed_o  out  2  speed code: 00 stop, 01 low, 11 middle, 10 high.
- level_o  out  2  current difficulty level, 0..3.
- spawn_total_o  out  16  accepted spawns since reset, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - spawn_valid_o=0, spawn_x_o=0, spawn_speed_o=2'b00, level_o=0, spawn_total_o=0.
  - Interval counter=0, level spawn counter=0, state=COUNT, LFSR=SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts every clk_run cycle after reset in every state, regardless of en_i and clear_i.
- X mapping:
  - cand = lfsr[9:0]; X_RANGE = H_DISP-X_SIZE+1 = 584.
  - x = (cand >= X_RANGE) ? cand-X_RANGE : cand, which always lies in 0..583.
  - Computed combinationally, sampled on the COUNT->OFFER transition.
- Interval: interval = max(BASE_INTERVAL >> level, MIN_INTERVAL). With defaults: 200, 100, 50, 40.
- States:
  - COUNT:
    - If en_i=1, the counter increments each cycle.
    - When counter == interval-1 with en_i=1: counter<=0, latch spawn_x_o and spawn_speed_o, set spawn_valid_o=1, go to OFFER.
    - If en_i=0, the counter holds.
  - OFFER:
    - spawn_valid_o=1; spawn_x_o and spawn_speed_o are held stable.
    - Transfer occurs on a cycle with spawn_valid_o & spawn_ready_i. On transfer: spawn_valid_o<=0, go to COUNT (counter already 0), spawn_total_o+1 saturating at 16'hFFFF, level spawn counter+1.
    - en_i=0 in OFFER does not retract the offer.
    - The interval counter does not run in OFFER, so back-pressure delays all later spawns.
- Level update:
  - When the level spawn counter reaches LEVEL_STEP on a transfer, the counter goes to 0 and level_o increments, saturating at 3.
  - The new interval applies from the next COUNT period.
- Speed selection uses lfsr[15] at the latch cycle:
  - level 0: 01.
  - level 1: lfsr[15] ? 11 : 01.
  - level 2: lfsr[15] ? 10 : 11.
  - level 3: 10.
- clear_i (synchronous, highest priority after reset):
  - Returns every register except the LFSR to its reset value, including dropping spawn_valid_o in the same cycle.
  - clear_i together with a handshake: clear wins; the transfer is not counted.
- Boundaries:
  - cand=583 gives x=583; cand=584 gives x=0; cand=1023 gives x=439.
  - spawn_ready_i held high permanently gives exactly one spawn per interval+1 cycles (interval counting plus 1 OFFER cycle).

Test Plan:
- Reset, en_i=1, spawn_ready_i=1 -> first spawn_valid_o at cycle 200 after rst_n rises, lasting 1 cycle; next at cycle 401; spawn_speed_o=01; spawn_x_o always <=583.
- Force LFSR low bits to 583, 584 and 1023 at the latch cycle -> spawn_x_o = 583, 0 and 439 respectively.
- spawn_ready_i=0 for 500 cycles during OFFER -> spawn_valid_o stays 1 with x and speed unchanged and no second offer; ready=1 -> transfer, spawn_total_o+1, the next offer 200 cycles later.
- 8 accepted spawns -> level_o=1 and the next interval is 100; after 32 spawns level_o=3, interval 40, speed 10; level_o does not exceed 3.
- en_i toggled low for 50 cycles mid-COUNT -> the offer is delayed by exactly 50 cycles; en_i low during OFFER keeps spawn_valid_o=1.
- clear_i asserted during OFFER with spawn_ready_i=1 -> spawn_valid_o=0 next cycle, spawn_total_o and level_o are 0; rst_n pulse mid-COUNT -> all outputs at reset values immediately, asynchronously.
